iq_dispatch_ctrl: RTL

// Instruction queue and dispatch scheduler between IF and the IS decode stage.

---
 rtl/iq_if.sv | 24 ++
 rtl/iq_dispatch_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/iq_if.sv
// IF -> IQ -> IS handshake bundle: fetch push, downstream resource fullness, flush, dispatch.
interface iq_if;
    logic        iIF_En;
    logic [31:0] iIF_Pc;
    logic [31:0] iIF_Ins;
    logic        oIF_Stall;
    logic        iROB_Full;
    logic        iRS_Full;
    logic        iLSB_Full;
    logic        iROB_Flush;
    logic        oIS_En;
    logic [31:0] oIS_Pc;
    logic [31:0] oIS_Ins;

    modport master (
        output iIF_En, iIF_Pc, iIF_Ins, iROB_Full, iRS_Full, iLSB_Full, iROB_Flush,
        input  oIF_Stall, oIS_En, oIS_Pc, oIS_Ins
    );

    modport slave (
        input  iIF_En, iIF_Pc, iIF_Ins, iROB_Full, iRS_Full, iLSB_Full, iROB_Flush,
        output oIF_Stall, oIS_En, oIS_Pc, oIS_Ins
    );
endinterface

// File: rtl/iq_dispatch_ctrl.sv
// In-order instruction queue with resource-gated single dispatch to IS.
// Optional feature macro IQ_BYPASS_EN: empty-queue dispatchable fetches skip the queue.
module iq_dispatch_ctrl #(
    parameter int IQ_ADDR_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    iq_if.slave         bus,
    output logic [31:0] oStallCnt
);
    localparam int DEPTH = 1 << IQ_ADDR_W;
    localparam logic [IQ_ADDR_W:0] DEPTH_C   = DEPTH[IQ_ADDR_W:0];
    localparam logic [IQ_ADDR_W:0] DEPTH_M1  = DEPTH_C - 1'b1;
    localparam logic [IQ_ADDR_W:0] CNT_ZERO  = '0;

    typedef enum logic [1:0] {IDLE, RUN, STALL, FLUSH} state_t;

    state_t               state_q, state_d;
    logic [IQ_ADDR_W-1:0] head_q, tail_q;
    logic [IQ_ADDR_W:0]   cnt_q, cnt_d;
    logic [31:0]          pc_mem  [DEPTH];
    logic [31:0]          ins_mem [DEPTH];
    logic                 is_en_q, stall_q;
    logic [31:0]          is_pc_q, is_ins_q, scnt_q;

    logic [31:0] head_ins;
    logic        head_ok, blocked, in_flush, pop, push, byp;

    function automatic logic res_ok(input logic [31:0] ins, input logic rob_f,
                                    input logic rs_f, input logic lsb_f);
        logic is_mem;
        is_mem = (ins[6:0] == 7'b0000011) || (ins[6:0] == 7'b0100011);
        return !rob_f && (is_mem ? !lsb_f : !rs_f);
    endfunction

    assign head_ins = ins_mem[head_q];
    assign head_ok  = res_ok(head_ins, bus.iROB_Full, bus.iRS_Full, bus.iLSB_Full);
    assign blocked  = (cnt_q != CNT_ZERO) && !head_ok;

    // Output/control decode from state and inputs
    always_comb begin
        in_flush = (state_q == FLUSH);
        pop      = en && !bus.iROB_Flush && !in_flush && (cnt_q != CNT_ZERO) && head_ok;
`ifdef IQ_BYPASS_EN
        byp      = en && !bus.iROB_Flush && !in_flush && (cnt_q == CNT_ZERO) && bus.iIF_En &&
                   res_ok(bus.iIF_Ins, bus.iROB_Full, bus.iRS_Full, bus.iLSB_Full);
`else
        byp      = 1'b0;
`endif
        push     = en && !bus.iROB_Flush && !in_flush && bus.iIF_En && !byp &&
                   ((cnt_q < DEPTH_C) || pop);
        if (bus.iROB_Flush)
            cnt_d = CNT_ZERO;
        else
            cnt_d = cnt_q + {{IQ_ADDR_W{1'b0}}, push} - {{IQ_ADDR_W{1'b0}}, pop};
    end

    always_comb begin
        state_d = state_q;
        if (en) begin
            if (bus.iROB_Flush)
                state_d = FLUSH;
            else if (state_q == FLUSH)
                state_d = IDLE;
            else if (cnt_d == CNT_ZERO)
                state_d = IDLE;
            else if (blocked)
                state_d = STALL;
            else
                state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_q]  <= bus.iIF_Pc;
            ins_mem[tail_q] <= bus.iIF_Ins;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            cnt_q    <= '0;
            is_en_q  <= 1'b0;
            is_pc_q  <= '0;
            is_ins_q <= '0;
            stall_q  <= 1'b0;
            scnt_q   <= '0;
        end else if (en) begin
            if (bus.iROB_Flush) begin
                head_q <= '0;
                tail_q <= '0;
            end else begin
                if (pop)  head_q <= head_q + 1'b1;
                if (push) tail_q <= tail_q + 1'b1;
            end
            cnt_q    <= cnt_d;
            is_en_q  <= pop || byp;
            is_pc_q  <= pop ? pc_mem[head_q] : (byp ? bus.iIF_Pc  : '0);
            is_ins_q <= pop ? head_ins       : (byp ? bus.iIF_Ins : '0);
            // IF reacts one cycle late, so warn one slot before full
            stall_q  <= (cnt_d >= DEPTH_M1);
            if (blocked) scnt_q <= scnt_q + 32'd1;
        end else begin
            is_en_q  <= 1'b0;
            is_pc_q  <= '0;
            is_ins_q <= '0;
        end
    end

    assign bus.oIS_En    = is_en_q;
    assign bus.oIS_Pc    = is_pc_q;
    assign bus.oIS_Ins   = is_ins_q;
    assign bus.oIF_Stall = stall_q;
    assign oStallCnt     = scnt_q;
endmodule
